// File: rtl/risc16_io_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : risc16_io_if
// Purpose  : Data-memory bus between the risc16 core and the I/O responder.
// Signals  : addr    - data address (core -> io)
//            rw      - 1 = write, 0 = read (core -> io)
//            mem_in  - write data (core -> io)
//            mem_out - combinational read data (io -> core)
//            io_hit  - address falls inside the I/O window (io -> core)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface risc16_io_if;
    logic [15:0] addr;
    logic        rw;
    logic [15:0] mem_in;
    logic [15:0] mem_out;
    logic        io_hit;

    modport master (
        output addr,
        output rw,
        output mem_in,
        input  mem_out,
        input  io_hit
    );

    modport slave (
        input  addr,
        input  rw,
        input  mem_in,
        output mem_out,
        output io_hit
    );
endinterface
`default_nettype wire

// File: rtl/risc16_io.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : risc16_io
// Purpose  : Memory-mapped I/O responder for the risc16 core. Decodes the
//            window 0x0000..IO_TOP and provides the system control register,
//            a free-running 32-bit cycle counter with high-half snapshot, and
//            an 8N1 UART transmitter fed by a small TX FIFO.
// Ports    : clk      - system clock, all state on posedge
//            rst      - synchronous active-high reset
//            bus      - data-memory bus (slave side): addr, rw, mem_in in;
//                       mem_out (combinational read data), io_hit out
//            sys_ctrl - system control register, bit0 = halt (sticky)
//            txd      - registered UART serial output, idle high
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module risc16_io #(
    parameter logic [15:0] IO_TOP       = 16'h000E,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] CLKS_PER_BIT = 16'd434
) (
    input  wire logic         clk,
    input  wire logic         rst,
    risc16_io_if.slave        bus,
    output logic [15:0]       sys_ctrl,
    output logic              txd
);

    localparam int          c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int          c_CNT_W  = c_PTR_W + 1;

    localparam logic [15:0] c_A_SYS  = 16'h0000;
    localparam logic [15:0] c_A_TX   = 16'h0001;
    localparam logic [15:0] c_A_STAT = 16'h0002;
    localparam logic [15:0] c_A_CLO  = 16'h0003;
    localparam logic [15:0] c_A_CHI  = 16'h0004;
    localparam logic [15:0] c_A_BAUD = 16'h0005;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Registers
    logic [15:0]        sys_ctrl_q;
    logic [15:0]        baud_div_q;
    logic               ovf_q;
    logic [31:0]        cyc_q;
    logic [15:0]        cyc_hi_snap_q;
    logic [7:0]         fifo_mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_CNT_W-1:0] fifo_cnt_q;

    state_t             state_q,    state_d;
    logic [15:0]        baud_cnt_q, baud_cnt_d;
    logic [2:0]         bit_cnt_q,  bit_cnt_d;
    logic [7:0]         shift_q,    shift_d;
    logic               txd_q,      txd_d;

    // Decode
    logic        w_hit;
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_sys;
    logic        w_wr_tx;
    logic        w_wr_stat;
    logic        w_wr_baud;
    logic        w_rd_clo;

    assign w_hit     = (bus.addr <= IO_TOP);
    assign w_wr      = w_hit &  bus.rw;
    assign w_rd      = w_hit & ~bus.rw;
    assign w_wr_sys  = w_wr && (bus.addr == c_A_SYS);
    assign w_wr_tx   = w_wr && (bus.addr == c_A_TX);
    assign w_wr_stat = w_wr && (bus.addr == c_A_STAT);
    assign w_wr_baud = w_wr && (bus.addr == c_A_BAUD);
    assign w_rd_clo  = w_rd && (bus.addr == c_A_CLO);

    // FIFO status and handshakes
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_ovf_set;

    assign w_full    = (fifo_cnt_q == c_CNT_W'(FIFO_DEPTH));
    assign w_empty   = (fifo_cnt_q == '0);
    // The FSM only pops from a registered non-empty count, so a byte pushed
    // into an empty FIFO is popped on the following edge, not the same one.
    assign w_pop     = (state_q == S_IDLE) && !w_empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign w_push    = w_wr_tx && (!w_full || w_pop);
    assign w_ovf_set = w_wr_tx &&  w_full && !w_pop;

    // A divider of 0 is treated as 1 so every bit lasts at least one cycle.
    logic [15:0] w_div_eff;
    assign w_div_eff = (baud_div_q == 16'd0) ? 16'd1 : baud_div_q;

    // Control/status registers, counter, FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            sys_ctrl_q    <= 16'h0000;
            baud_div_q    <= CLKS_PER_BIT;
            ovf_q         <= 1'b0;
            cyc_q         <= 32'd0;
            cyc_hi_snap_q <= 16'h0000;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;

            if (w_wr_sys) begin
                // halt (bit0) is sticky: it can be set but never cleared here
                sys_ctrl_q <= {bus.mem_in[15:1], sys_ctrl_q[0] | bus.mem_in[0]};
            end

            if (w_wr_baud) begin
                baud_div_q <= bus.mem_in;
            end

            if (w_ovf_set) begin
                ovf_q <= 1'b1;
            end else if (w_wr_stat && bus.mem_in[3]) begin
                ovf_q <= 1'b0;
            end

            // Snapshot the live high half as the low half is read, so a
            // following CYC_HI read is coherent with the CYC_LO value.
            if (w_rd_clo) begin
                cyc_hi_snap_q <= cyc_q[31:16];
            end

            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + c_CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - c_CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= bus.mem_in[7:0];
        end
    end

    // UART transmitter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
        end
    end

    // UART next state. The baud counter is reloaded from BAUD_DIV only at a
    // bit start, so divider changes never stretch or cut a bit in flight.
    logic w_bit_done;
    assign w_bit_done = (baud_cnt_q <= 16'd1);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        txd_d      = txd_q;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!w_empty) begin
                    shift_d    = fifo_mem_q[rd_ptr_q];
                    baud_cnt_d = w_div_eff;
                    txd_d      = 1'b0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    baud_cnt_d = w_div_eff;
                    bit_cnt_d  = 3'd0;
                    txd_d      = shift_q[0];
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    baud_cnt_d = w_div_eff;
                    if (bit_cnt_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    state_d = S_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Combinational read path
    logic [15:0] w_status;
    logic [15:0] w_rdata;

    assign w_status = {8'h00, 4'(fifo_cnt_q), ovf_q, (state_q != S_IDLE),
                       w_empty, w_full};

    always_comb begin
        w_rdata = 16'h0000;
        if (w_hit) begin
            case (bus.addr)
                c_A_SYS:  w_rdata = sys_ctrl_q;
                c_A_STAT: w_rdata = w_status;
                c_A_CLO:  w_rdata = cyc_q[15:0];
                c_A_CHI:  w_rdata = cyc_hi_snap_q;
                c_A_BAUD: w_rdata = baud_div_q;
                default:  w_rdata = 16'h0000;
            endcase
        end
    end

    assign bus.mem_out = w_rdata;
    assign bus.io_hit  = w_hit;
    assign sys_ctrl    = sys_ctrl_q;
    assign txd         = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_risc16_io.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_risc16_io
// Purpose  : Directed self-checking bench for risc16_io. Inputs change on the
//            falling edge, outputs are sampled shortly after it, so every
//            write commits on the following rising edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_risc16_io;

    localparam logic [15:0] c_CLKS = 16'd434;
    localparam logic [15:0] c_IDLE_ADDR = 16'h00FF;

    logic        clk;
    logic        rst;
    logic [15:0] sys_ctrl;
    logic        txd;

    int n_checks;
    int n_fails;

    risc16_io_if bus ();

    risc16_io #(
        .IO_TOP       (16'h000E),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (c_CLKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sys_ctrl (sys_ctrl),
        .txd      (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: drive after negedge, commit on posedge, release after.
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.addr   = a;
        bus.rw     = 1'b1;
        bus.mem_in = d;
        @(posedge clk);
        #1;
        bus.addr   = c_IDLE_ADDR;
        bus.rw     = 1'b0;
        bus.mem_in = 16'h0000;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.rw   = 1'b0;
        #1;
        d = bus.mem_out;
        @(posedge clk);
        #1;
        bus.addr = c_IDLE_ADDR;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (txd !== 1'b1) begin
            n_fails++; $display("FAIL reset_txd: got %b expected 1", txd);
        end
        n_checks++;
        if (sys_ctrl !== 16'h0000) begin
            n_fails++; $display("FAIL reset_sys_ctrl: got %h expected 0000", sys_ctrl);
        end
        bus_read(16'h0002, d);
        n_checks++;
        if (d !== 16'h0002) begin
            n_fails++; $display("FAIL reset_status: got %h expected 0002", d);
        end
        bus_read(16'h0005, d);
        n_checks++;
        if (d !== c_CLKS) begin
            n_fails++; $display("FAIL reset_baud: got %h expected %h", d, c_CLKS);
        end
        bus_read(16'h0000, d);
        n_checks++;
        if (d !== 16'h0000) begin
            n_fails++; $display("FAIL reset_addr0: got %h expected 0000", d);
        end
        bus_read(16'h0004, d);
        n_checks++;
        if (d !== 16'h0000) begin
            n_fails++; $display("FAIL reset_cyc_hi: got %h expected 0000", d);
        end
    endtask

    task automatic test_serial_frame();
        logic [7:0] byte_v;
        logic       exp_txd  [42];
        logic       exp_busy [42];
        byte_v = 8'hA5;
        exp_txd[0] = 1'b1; exp_busy[0] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_txd[i] = 1'b0; exp_busy[i] = 1'b1;
        end
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 4; k++) begin
                exp_txd[5 + b*4 + k]  = byte_v[b];
                exp_busy[5 + b*4 + k] = 1'b1;
            end
        end
        for (int i = 37; i <= 40; i++) begin
            exp_txd[i] = 1'b1; exp_busy[i] = 1'b1;
        end
        exp_txd[41] = 1'b1; exp_busy[41] = 1'b0;

        bus_write(16'h0005, 16'd4);
        bus_write(16'h0001, 16'h00A5);
        bus.addr = 16'h0002;
        bus.rw   = 1'b0;
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (txd !== exp_txd[i]) begin
                n_fails++;
                $display("FAIL frame_txd[%0d]: got %b expected %b", i, txd, exp_txd[i]);
            end
            n_checks++;
            if (bus.mem_out[2] !== exp_busy[i]) begin
                n_fails++;
                $display("FAIL frame_busy[%0d]: got %b expected %b", i, bus.mem_out[2], exp_busy[i]);
            end
        end
        bus.addr = c_IDLE_ADDR;
    endtask

    task automatic test_fifo_overflow();
        logic [15:0] d;
        int          frames;
        logic        prev_busy;
        bus_write(16'h0005, 16'd100);
        for (int i = 0; i < 6; i++) begin
            bus_write(16'h0001, 16'h0010 + 16'(i));
        end
        // count 4, OVF, BUSY, FULL
        bus_read(16'h0002, d);
        n_checks++;
        if (d !== 16'h004D) begin
            n_fails++; $display("FAIL ovf_status: got %h expected 004D", d);
        end
        bus_write(16'h0002, 16'h0008);
        bus_read(16'h0002, d);
        n_checks++;
        if (d !== 16'h0045) begin
            n_fails++; $display("FAIL ovf_clear: got %h expected 0045", d);
        end
        // Count frame ends (BUSY falling) within a bounded window.
        frames    = 0;
        prev_busy = 1'b1;
        bus.addr  = 16'h0002;
        bus.rw    = 1'b0;
        for (int i = 0; i < 5600; i++) begin
            @(negedge clk);
            #1;
            if (prev_busy && !bus.mem_out[2]) frames++;
            prev_busy = bus.mem_out[2];
        end
        n_checks++;
        if (frames != 5) begin
            n_fails++; $display("FAIL ovf_frames: got %0d expected 5", frames);
        end
        n_checks++;
        if (bus.mem_out !== 16'h0002) begin
            n_fails++; $display("FAIL ovf_drained: got %h expected 0002", bus.mem_out);
        end
        bus.addr = c_IDLE_ADDR;
    endtask

    task automatic test_halt();
        logic [15:0] d;
        bus_write(16'h0000, 16'h0001);
        n_checks++;
        if (sys_ctrl !== 16'h0001) begin
            n_fails++; $display("FAIL halt_set: got %h expected 0001", sys_ctrl);
        end
        bus_write(16'h0000, 16'h0000);
        n_checks++;
        if (sys_ctrl !== 16'h0001) begin
            n_fails++; $display("FAIL halt_sticky: got %h expected 0001", sys_ctrl);
        end
        bus_write(16'h0000, 16'hABCE);
        bus_read(16'h0000, d);
        n_checks++;
        if (d !== 16'hABCF) begin
            n_fails++; $display("FAIL halt_scratch: got %h expected ABCF", d);
        end
        // Reset wins over a simultaneous write.
        @(negedge clk);
        rst        = 1'b1;
        bus.addr   = 16'h0000;
        bus.rw     = 1'b1;
        bus.mem_in = 16'hFFFF;
        @(posedge clk);
        #1;
        n_checks++;
        if (sys_ctrl !== 16'h0000) begin
            n_fails++; $display("FAIL halt_reset: got %h expected 0000", sys_ctrl);
        end
        @(negedge clk);
        rst        = 1'b0;
        bus.addr   = c_IDLE_ADDR;
        bus.rw     = 1'b0;
        bus.mem_in = 16'h0000;
    endtask

    task automatic test_decode();
        logic [15:0] d;
        bus_write(16'h0008, 16'hFFFF);
        bus_read(16'h0008, d);
        n_checks++;
        if (d !== 16'h0000) begin
            n_fails++; $display("FAIL dec_unlisted: got %h expected 0000", d);
        end
        n_checks++;
        if (sys_ctrl !== 16'h0000) begin
            n_fails++; $display("FAIL dec_sys_unchanged: got %h expected 0000", sys_ctrl);
        end
        bus_read(16'h0002, d);
        n_checks++;
        if (d !== 16'h0002) begin
            n_fails++; $display("FAIL dec_status_unchanged: got %h expected 0002", d);
        end
        bus_read(16'h0001, d);
        n_checks++;
        if (d !== 16'h0000) begin
            n_fails++; $display("FAIL dec_txdata_read: got %h expected 0000", d);
        end
        @(negedge clk);
        bus.addr   = 16'h000F;
        bus.rw     = 1'b1;
        bus.mem_in = 16'h0001;
        #1;
        n_checks++;
        if (bus.io_hit !== 1'b0) begin
            n_fails++; $display("FAIL dec_hit_0F: got %b expected 0", bus.io_hit);
        end
        @(negedge clk);
        bus.rw     = 1'b0;
        bus.mem_in = 16'h0000;
        bus.addr   = 16'h000E;
        #1;
        n_checks++;
        if (bus.io_hit !== 1'b1) begin
            n_fails++; $display("FAIL dec_hit_0E: got %b expected 1", bus.io_hit);
        end
        n_checks++;
        if (sys_ctrl !== 16'h0000) begin
            n_fails++; $display("FAIL dec_0F_write: got %h expected 0000", sys_ctrl);
        end
        bus.addr = c_IDLE_ADDR;
    endtask

    task automatic test_reset_midframe();
        logic [15:0] d;
        int          lows;
        bus_write(16'h0005, 16'd4);
        bus_write(16'h0001, 16'h003C);
        bus_write(16'h0001, 16'h00C3);
        // Start bit ends 4 cycles after the pop; this lands inside DATA.
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (txd !== 1'b1) begin
            n_fails++; $display("FAIL mid_txd: got %b expected 1", txd);
        end
        @(negedge clk);
        rst      = 1'b0;
        bus.addr = 16'h0002;
        bus.rw   = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_out !== 16'h0002) begin
            n_fails++; $display("FAIL mid_status: got %h expected 0002", bus.mem_out);
        end
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (txd !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != 0) begin
            n_fails++; $display("FAIL mid_no_frame: got %0d low cycles expected 0", lows);
        end
        bus.addr = c_IDLE_ADDR;
        bus_read(16'h0005, d);
        n_checks++;
        if (d !== c_CLKS) begin
            n_fails++; $display("FAIL mid_baud_reset: got %h expected %h", d, c_CLKS);
        end
    endtask

    task automatic test_counter_snapshot();
        logic [15:0] d;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // Counter is 0 now and steps on every following edge.
        repeat (65535) @(posedge clk);
        bus_read(16'h0003, d);
        n_checks++;
        if (d !== 16'hFFFF) begin
            n_fails++; $display("FAIL cyc_lo: got %h expected FFFF", d);
        end
        bus_read(16'h0004, d);
        n_checks++;
        if (d !== 16'h0000) begin
            n_fails++; $display("FAIL cyc_hi_snap: got %h expected 0000", d);
        end
        bus_read(16'h0003, d);
        n_checks++;
        if (d !== 16'h0001) begin
            n_fails++; $display("FAIL cyc_lo_wrap: got %h expected 0001", d);
        end
        bus_read(16'h0004, d);
        n_checks++;
        if (d !== 16'h0001) begin
            n_fails++; $display("FAIL cyc_hi_live: got %h expected 0001", d);
        end
        bus_write(16'h0003, 16'h1234);
        bus_read(16'h0003, d);
        n_checks++;
        if (d !== 16'h0004) begin
            n_fails++; $display("FAIL cyc_write_ignored: got %h expected 0004", d);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        rst        = 1'b1;
        bus.addr   = c_IDLE_ADDR;
        bus.rw     = 1'b0;
        bus.mem_in = 16'h0000;

        test_reset();
        test_serial_frame();
        test_fifo_overflow();
        test_halt();
        test_decode();
        test_reset_midframe();
        test_counter_snapshot();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
